// File: rtl/shift_arbiter_if.sv
// Two-requester shift arbiter bus: requester A/B operand channels, response channel and per-requester counters.
interface shift_arbiter_if #(
    parameter int unsigned CNT_W = 16
);
    logic             a_valid;
    logic             a_ready;
    logic [31:0]      a_data;
    logic [4:0]       a_shamt;
    logic             a_dir;

    logic             b_valid;
    logic             b_ready;
    logic [31:0]      b_data;
    logic [4:0]       b_shamt;
    logic             b_dir;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_id;

    logic [CNT_W-1:0] a_count;
    logic [CNT_W-1:0] b_count;

    modport slave (
        input  a_valid, a_data, a_shamt, a_dir,
        input  b_valid, b_data, b_shamt, b_dir,
        input  rsp_ready,
        output a_ready, b_ready,
        output rsp_valid, rsp_data, rsp_id,
        output a_count, b_count
    );

    modport master (
        output a_valid, a_data, a_shamt, a_dir,
        output b_valid, b_data, b_shamt, b_dir,
        output rsp_ready,
        input  a_ready, b_ready,
        input  rsp_valid, rsp_data, rsp_id,
        input  a_count, b_count
    );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter feeding two requesters into one shared 32-bit barrel shifter with a single response register.
// Optional logical right shift via bit reversal when SHIFT_ARBITER_RIGHT_EN is defined; otherwise dir is ignored.
module shift_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    shift_arbiter_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SH_W   = 5;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]  a_count_q, a_count_d;
    logic [CNT_W-1:0]  b_count_q, b_count_d;

    logic              slot_free_c;
    logic              grant_a_c;
    logic              grant_b_c;
    logic              accept_c;
    logic              handshake_c;
    logic [DATA_W-1:0] operand_c;
    logic [SH_W-1:0]   shamt_c;
    logic [DATA_W-1:0] shift_in_c;
    logic [DATA_W-1:0] shift_out_c;
    logic [DATA_W-1:0] result_c;

    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < int'(DATA_W); i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

    // Slot is free when empty or when the held response leaves this cycle; the loser of the last accept wins a tie.
    always_comb begin
        slot_free_c = (state_q == ST_EMPTY) | bus.rsp_ready;
        grant_a_c   = slot_free_c & bus.a_valid & (~bus.b_valid | (last_grant_q == GNT_B));
        grant_b_c   = slot_free_c & bus.b_valid & (~bus.a_valid | (last_grant_q == GNT_A));
        accept_c    = grant_a_c | grant_b_c;
        handshake_c = (state_q == ST_FULL) & bus.rsp_ready;
    end

    always_comb begin
        operand_c = grant_b_c ? bus.b_data  : bus.a_data;
        shamt_c   = grant_b_c ? bus.b_shamt : bus.a_shamt;
    end

`ifdef SHIFT_ARBITER_RIGHT_EN
    logic dir_c;

    // Right shift reuses the left shifter by mirroring operand and result.
    always_comb begin
        dir_c      = grant_b_c ? bus.b_dir : bus.a_dir;
        shift_in_c = dir_c ? bit_rev(operand_c) : operand_c;
        result_c   = dir_c ? bit_rev(shift_out_c) : shift_out_c;
    end
`else
    logic unused_dir_c;
    assign unused_dir_c = bus.a_dir ^ bus.b_dir;

    always_comb begin
        shift_in_c = operand_c;
        result_c   = shift_out_c;
    end
`endif

    // Shared shifter: five cascaded stages of 1/2/4/8/16.
    always_comb begin
        shift_out_c = shift_in_c;
        for (int s = 0; s < int'(SH_W); s++) begin
            if (shamt_c[s]) begin
                shift_out_c = shift_out_c << (1 << s);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        a_count_d    = a_count_q;
        b_count_d    = b_count_q;

        case (state_q)
            ST_EMPTY: if (accept_c) state_d = ST_FULL;
            ST_FULL:  if (bus.rsp_ready && !accept_c) state_d = ST_EMPTY;
        endcase

        if (accept_c) begin
            rsp_data_d   = result_c;
            rsp_id_d     = grant_b_c ? GNT_B : GNT_A;
            last_grant_d = grant_b_c ? GNT_B : GNT_A;
        end

        if (handshake_c) begin
            if (rsp_id_q == GNT_A && a_count_q != CNT_MAX) a_count_d = a_count_q + CNT_W'(1);
            if (rsp_id_q == GNT_B && b_count_q != CNT_MAX) b_count_d = b_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            last_grant_q <= GNT_B;
            rsp_data_q   <= '0;
            rsp_id_q     <= GNT_A;
            a_count_q    <= '0;
            b_count_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            a_count_q    <= a_count_d;
            b_count_q    <= b_count_d;
        end
    end

    assign bus.a_ready   = grant_a_c;
    assign bus.b_ready   = grant_b_c;
    assign bus.rsp_valid = (state_q == ST_FULL);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.a_count   = a_count_q;
    assign bus.b_count   = b_count_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_shift_arbiter;
    logic clk;
    logic rst_n;

    shift_arbiter_if #(.CNT_W(16)) mif ();
    shift_arbiter_if #(.CNT_W(2))  sif ();

    shift_arbiter #(.CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(mif.slave));
    shift_arbiter #(.CNT_W(2))  u_sat (.clk(clk), .rst_n(rst_n), .bus(sif.slave));

    // The narrow-counter instance sees exactly the same traffic.
    assign sif.a_valid   = mif.a_valid;
    assign sif.a_data    = mif.a_data;
    assign sif.a_shamt   = mif.a_shamt;
    assign sif.a_dir     = mif.a_dir;
    assign sif.b_valid   = mif.b_valid;
    assign sif.b_data    = mif.b_data;
    assign sif.b_shamt   = mif.b_shamt;
    assign sif.b_dir     = mif.b_dir;
    assign sif.rsp_ready = mif.rsp_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: one response slot, id of last winner, completed counts.
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_id;
    logic        m_last;
    int          m_acnt;
    int          m_bcnt;
    logic        exp_a;
    logic        exp_b;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sh, input logic dir);
`ifdef SHIFT_ARBITER_RIGHT_EN
        if (dir) return d >> sh;
`else
        if (dir) return d << sh;
`endif
        return d << sh;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic reset_model();
        m_valid = 1'b0; m_data = '0; m_id = 1'b0; m_last = 1'b1;
        m_acnt = 0; m_bcnt = 0; exp_a = 1'b0; exp_b = 1'b0;
    endtask

    task automatic apply(input logic av, input logic [31:0] ad, input logic [4:0] as, input logic adr,
                         input logic bv, input logic [31:0] bd, input logic [4:0] bs, input logic bdr,
                         input logic rr);
        logic free;
        @(negedge clk);
        mif.a_valid = av; mif.a_data = ad; mif.a_shamt = as; mif.a_dir = adr;
        mif.b_valid = bv; mif.b_data = bd; mif.b_shamt = bs; mif.b_dir = bdr;
        mif.rsp_ready = rr;
        free  = !m_valid || rr;
        exp_a = free && av && (!bv || m_last);
        exp_b = free && bv && (!av || !m_last);
        #1;
    endtask

    task automatic apply_idle(input logic rr);
        apply(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, rr);
    endtask

    task automatic advance();
        @(posedge clk);
        if (m_valid && mif.rsp_ready) begin
            if (m_id) m_bcnt++; else m_acnt++;
            m_valid = 1'b0;
        end
        if (exp_a) begin
            m_valid = 1'b1; m_id = 1'b0; m_last = 1'b0;
            m_data = ref_shift(mif.a_data, mif.a_shamt, mif.a_dir);
        end else if (exp_b) begin
            m_valid = 1'b1; m_id = 1'b1; m_last = 1'b1;
            m_data = ref_shift(mif.b_data, mif.b_shamt, mif.b_dir);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mif.a_valid = 1'b0; mif.b_valid = 1'b0; mif.rsp_ready = 1'b0;
        #2;
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        n_vec++; if (mif.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", mif.rsp_valid); end
        n_vec++; if (mif.rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_rsp_data got %h want 0", mif.rsp_data); end
        n_vec++; if (mif.rsp_id !== 1'b0) begin n_err++; $display("FAIL reset_rsp_id got %b want 0", mif.rsp_id); end
        n_vec++; if (mif.a_count !== 16'd0 || mif.b_count !== 16'd0) begin n_err++; $display("FAIL reset_counts got %0d/%0d want 0/0", mif.a_count, mif.b_count); end
        n_vec++; if (sif.a_count !== 2'd0 || sif.b_count !== 2'd0) begin n_err++; $display("FAIL reset_sat_counts got %0d/%0d want 0/0", sif.a_count, sif.b_count); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_left_basic();
        apply(1'b1, 32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        n_vec++; if (mif.a_ready !== 1'b1 || mif.b_ready !== 1'b0) begin n_err++; $display("FAIL left_ready got a=%b b=%b want a=1 b=0", mif.a_ready, mif.b_ready); end
        advance();
        apply_idle(1'b1);
        n_vec++; if (mif.rsp_valid !== 1'b1) begin n_err++; $display("FAIL left_rsp_valid got %b want 1", mif.rsp_valid); end
        n_vec++; if (mif.rsp_data !== 32'h8000_0000) begin n_err++; $display("FAIL left_rsp_data got %h want 80000000", mif.rsp_data); end
        n_vec++; if (mif.rsp_id !== 1'b0) begin n_err++; $display("FAIL left_rsp_id got %b want 0", mif.rsp_id); end
        advance();
        apply_idle(1'b1);
        n_vec++; if (mif.a_count !== 16'd1 || mif.rsp_valid !== 1'b0) begin n_err++; $display("FAIL left_count got cnt=%0d valid=%b want cnt=1 valid=0", mif.a_count, mif.rsp_valid); end
        advance();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            logic want_id;
            logic act;
            act = (i < 4);
            apply(act, $urandom, 5'($urandom), 1'b0, act, $urandom, 5'($urandom), 1'b0, 1'b1);
            if (i > 0) begin
                want_id = 1'((i - 1) % 2);
                n_vec++; if (mif.rsp_valid !== 1'b1 || mif.rsp_id !== want_id || mif.rsp_data !== m_data) begin
                    n_err++; $display("FAIL rr_rsp[%0d] got v=%b id=%b d=%h want v=1 id=%b d=%h", i, mif.rsp_valid, mif.rsp_id, mif.rsp_data, want_id, m_data); end
            end
            if (act) begin
                want_id = 1'(i % 2);
                n_vec++; if (mif.a_ready !== !want_id || mif.b_ready !== want_id) begin
                    n_err++; $display("FAIL rr_grant[%0d] got a=%b b=%b want a=%b b=%b", i, mif.a_ready, mif.b_ready, !want_id, want_id); end
            end
            advance();
        end
        apply_idle(1'b1);
        n_vec++; if (mif.a_count !== 16'd2 || mif.b_count !== 16'd2) begin n_err++; $display("FAIL rr_counts got %0d/%0d want 2/2", mif.a_count, mif.b_count); end
        advance();
    endtask

    task automatic test_backpressure();
        logic [31:0] a0, b1;
        logic [31:0] held;
        a0 = $urandom;
        b1 = $urandom;
        held = a0 << 3;
        apply(1'b1, a0, 5'd3, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        advance();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, $urandom, 5'($urandom), 1'b0, 1'b1, $urandom, 5'($urandom), 1'b0, 1'b0);
            n_vec++; if (mif.a_ready !== 1'b0 || mif.b_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d] got a=%b b=%b want 0/0", i, mif.a_ready, mif.b_ready); end
            n_vec++; if (mif.rsp_valid !== 1'b1 || mif.rsp_data !== held) begin n_err++; $display("FAIL bp_hold[%0d] got v=%b d=%h want v=1 d=%h", i, mif.rsp_valid, mif.rsp_data, held); end
            advance();
        end
        apply(1'b1, 32'hFFFF_FFFF, 5'd1, 1'b0, 1'b1, b1, 5'd0, 1'b0, 1'b1);
        n_vec++; if (mif.a_ready !== 1'b0 || mif.b_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got a=%b b=%b want a=0 b=1", mif.a_ready, mif.b_ready); end
        advance();
        apply_idle(1'b1);
        n_vec++; if (mif.rsp_valid !== 1'b1 || mif.rsp_id !== 1'b1 || mif.rsp_data !== b1) begin
            n_err++; $display("FAIL bp_next got v=%b id=%b d=%h want v=1 id=1 d=%h", mif.rsp_valid, mif.rsp_id, mif.rsp_data, b1); end
        advance();
    endtask

    task automatic test_right();
        logic [31:0] want;
`ifdef SHIFT_ARBITER_RIGHT_EN
        want = 32'h0800_0000;
`else
        want = 32'h0000_0000;
`endif
        apply(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 32'h8000_0000, 5'd4, 1'b1, 1'b1);
        advance();
        apply_idle(1'b0);
        n_vec++; if (mif.rsp_id !== 1'b1 || mif.rsp_data !== want) begin n_err++; $display("FAIL right_shift got id=%b d=%h want id=1 d=%h", mif.rsp_id, mif.rsp_data, want); end
        advance();
        apply_idle(1'b1);
        advance();
    endtask

    task automatic test_reset_mid();
        apply(1'b1, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        advance();
        apply_idle(1'b0);
        n_vec++; if (mif.rsp_valid !== 1'b1 || mif.rsp_data !== 32'h1234_5678) begin n_err++; $display("FAIL mid_pre got v=%b d=%h want v=1 d=12345678", mif.rsp_valid, mif.rsp_data); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (mif.rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rsp_valid got %b want 0", mif.rsp_valid); end
        n_vec++; if (mif.a_count !== 16'd0 || mif.b_count !== 16'd0) begin n_err++; $display("FAIL mid_counts got %0d/%0d want 0/0", mif.a_count, mif.b_count); end
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 32'h0000_00F0, 5'd4, 1'b0, 1'b1, 32'h1, 5'd1, 1'b0, 1'b1);
        n_vec++; if (mif.a_ready !== 1'b1 || mif.b_ready !== 1'b0) begin n_err++; $display("FAIL mid_first_grant got a=%b b=%b want a=1 b=0", mif.a_ready, mif.b_ready); end
        advance();
        apply_idle(1'b1);
        n_vec++; if (mif.rsp_id !== 1'b0 || mif.rsp_data !== 32'h0000_0F00) begin n_err++; $display("FAIL mid_first_rsp got id=%b d=%h want id=0 d=00000f00", mif.rsp_id, mif.rsp_data); end
        advance();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(i < 5, $urandom, 5'($urandom), 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
            advance();
        end
        apply_idle(1'b1);
        n_vec++; if (sif.a_count !== 2'd3) begin n_err++; $display("FAIL sat_a_count got %0d want 3", sif.a_count); end
        n_vec++; if (mif.a_count !== 16'd5) begin n_err++; $display("FAIL wide_a_count got %0d want 5", mif.a_count); end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [4:0] as, bs;
            as = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 5'd31 : 5'd0) : 5'($urandom);
            bs = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 5'd31 : 5'd0) : 5'($urandom);
            apply(1'($urandom_range(0, 1)), $urandom, as, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom, bs, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0));
            n_vec++; if (mif.a_ready !== exp_a || mif.b_ready !== exp_b) begin
                n_err++; $display("FAIL rnd_ready[%0d] got a=%b b=%b want a=%b b=%b", i, mif.a_ready, mif.b_ready, exp_a, exp_b); end
            n_vec++; if (mif.rsp_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid[%0d] got %b want %b", i, mif.rsp_valid, m_valid); end
            if (m_valid) begin
                n_vec++; if (mif.rsp_data !== m_data || mif.rsp_id !== m_id) begin
                    n_err++; $display("FAIL rnd_rsp[%0d] got id=%b d=%h want id=%b d=%h", i, mif.rsp_id, mif.rsp_data, m_id, m_data); end
                n_vec++; if (sif.rsp_data !== m_data || sif.rsp_id !== m_id) begin
                    n_err++; $display("FAIL rnd_sat_rsp[%0d] got id=%b d=%h want id=%b d=%h", i, sif.rsp_id, sif.rsp_data, m_id, m_data); end
            end
            n_vec++; if (sif.rsp_valid !== m_valid || sif.a_ready !== exp_a || sif.b_ready !== exp_b) begin
                n_err++; $display("FAIL rnd_sat_hs[%0d] got v=%b a=%b b=%b want v=%b a=%b b=%b", i, sif.rsp_valid, sif.a_ready, sif.b_ready, m_valid, exp_a, exp_b); end
            n_vec++; if (mif.a_count !== 16'(sat(m_acnt, 65535)) || mif.b_count !== 16'(sat(m_bcnt, 65535))) begin
                n_err++; $display("FAIL rnd_counts[%0d] got %0d/%0d want %0d/%0d", i, mif.a_count, mif.b_count, m_acnt, m_bcnt); end
            n_vec++; if (sif.a_count !== 2'(sat(m_acnt, 3)) || sif.b_count !== 2'(sat(m_bcnt, 3))) begin
                n_err++; $display("FAIL rnd_sat_counts[%0d] got %0d/%0d want %0d/%0d", i, sif.a_count, sif.b_count, sat(m_acnt, 3), sat(m_bcnt, 3)); end
            advance();
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        mif.a_valid = 1'b0; mif.a_data = '0; mif.a_shamt = '0; mif.a_dir = 1'b0;
        mif.b_valid = 1'b0; mif.b_data = '0; mif.b_shamt = '0; mif.b_dir = 1'b0;
        mif.rsp_ready = 1'b0;
        reset_model();

        test_reset();
        test_left_basic();
        test_round_robin();
        test_backpressure();
        test_right();
        test_reset_mid();
        test_saturation();
        do_reset();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
